mac_array_ctrl: RTL

Sequencing controller for the M×M MAC array that computes one matrix product C = A×B per job. It accepts a job start with an inner dimension K, clears the array, and accepts K operand beats over a valid/ready stream (column k of A, row k of B). It broadcasts each beat across the array as an outer-product update, then holds the final accumulators under a valid/ready result handshake. It sits between the operand buffer/AXI front end and the mac array.

---
 rtl/mac_array_ctrl.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/mac_array_ctrl.sv
// mac_array_ctrl
// Sequencing controller for an M x M MAC array computing C = A x B per job.
// A job starts with an inner dimension k_len. The controller clears the array,
// then accepts k_len operand beats (column k of A, row k of B) over a
// valid/ready stream. Each beat is broadcast across the array as an
// outer-product update. The final accumulators are then held under a
// valid/ready result handshake.
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   start, k_len       job request (sampled in IDLE) and its inner dimension
//   abort              synchronous abort of a running job
//   op_valid/op_ready  operand beat handshake; op_a_col = A[*][k], op_b_row = B[k][*]
//   arr_a, arr_b       broadcast operands to the array
//   arr_en, arr_clr    array accumulate enable / synchronous clear
//   busy               job in progress (CLEAR through RESULT)
//   res_valid/res_ready result handshake; array holds C while res_valid
//   err                one-cycle pulse on an illegal start
module mac_array_ctrl #(
    parameter int A_WIDTH   = 8,
    parameter int B_WIDTH   = 8,
    parameter int ACC_WIDTH = 32,
    parameter int M         = 4,
    parameter int K_MAX     = 16,
    localparam int KW       = $clog2(K_MAX + 1)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [KW-1:0]             k_len,
    input  logic                      abort,
    input  logic                      op_valid,
    output logic                      op_ready,
    input  logic signed [A_WIDTH-1:0] op_a_col [M],
    input  logic signed [B_WIDTH-1:0] op_b_row [M],
    output logic signed [A_WIDTH-1:0] arr_a [M][M],
    output logic signed [B_WIDTH-1:0] arr_b [M][M],
    output logic                      arr_en,
    output logic                      arr_clr,
    output logic                      busy,
    output logic                      res_valid,
    input  logic                      res_ready,
    output logic                      err
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLEAR  = 3'd1,
        ST_RUN    = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_RESULT = 3'd4
    } state_t;

    localparam logic [KW-1:0] K_MAX_V = KW'(K_MAX);
    localparam logic [KW-1:0] K_ZERO  = {KW{1'b0}};
    localparam logic [KW-1:0] K_ONE   = {{(KW-1){1'b0}}, 1'b1};

    // The array must hold the widest possible sum without overflow.
    generate
        if (ACC_WIDTH < A_WIDTH + B_WIDTH + $clog2(K_MAX)) begin : g_acc_width_check
            $error("mac_array_ctrl: ACC_WIDTH too small for A_WIDTH+B_WIDTH+log2(K_MAX)");
        end
    endgenerate

    state_t                    state_r;
    logic [KW-1:0]             k_len_r;
    logic [KW-1:0]             beat_cnt_r;
    logic                      op_ready_r;
    logic                      arr_en_r;
    logic                      arr_clr_r;
    logic                      busy_r;
    logic                      res_valid_r;
    logic                      err_r;
    logic signed [A_WIDTH-1:0] arr_a_r [M][M];
    logic signed [B_WIDTH-1:0] arr_b_r [M][M];

    logic start_ok_s;
    logic abort_s;
    logic beat_s;
    logic last_beat_s;

    // Qualify start, abort and operand beats for the FSM.
    always_comb begin
        start_ok_s  = (k_len != K_ZERO) && (k_len <= K_MAX_V);
        abort_s     = abort && (state_r != ST_IDLE);
        // A beat offered during an abort cycle is refused, not accepted.
        beat_s      = op_valid && op_ready_r && !abort;
        last_beat_s = ((beat_cnt_r + K_ONE) == k_len_r);
    end

    // op_ready is the registered RUN-phase ready, masked by abort in the same
    // cycle so the producer never sees a discarded beat as taken.
    assign op_ready  = op_ready_r && !abort;
    assign arr_en    = arr_en_r;
    assign arr_clr   = arr_clr_r;
    assign busy      = busy_r;
    assign res_valid = res_valid_r;
    assign err       = err_r;
    assign arr_a     = arr_a_r;
    assign arr_b     = arr_b_r;

    // Job sequencing FSM with registered outputs and operand broadcast registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            k_len_r     <= K_ZERO;
            beat_cnt_r  <= K_ZERO;
            op_ready_r  <= 1'b0;
            arr_en_r    <= 1'b0;
            arr_clr_r   <= 1'b0;
            busy_r      <= 1'b0;
            res_valid_r <= 1'b0;
            err_r       <= 1'b0;
            for (int i = 0; i < M; i++) begin
                for (int j = 0; j < M; j++) begin
                    arr_a_r[i][j] <= {A_WIDTH{1'b0}};
                    arr_b_r[i][j] <= {B_WIDTH{1'b0}};
                end
            end
        end else begin
            // Pulsed outputs default low each cycle.
            arr_en_r  <= 1'b0;
            arr_clr_r <= 1'b0;
            err_r     <= 1'b0;
            if (abort_s) begin
                // Abort wins over every other transition; the array is wiped
                // in the following cycle so no partial result survives.
                state_r     <= ST_IDLE;
                op_ready_r  <= 1'b0;
                arr_clr_r   <= 1'b1;
                busy_r      <= 1'b0;
                res_valid_r <= 1'b0;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        if (start) begin
                            if (start_ok_s) begin
                                k_len_r    <= k_len;
                                beat_cnt_r <= K_ZERO;
                                state_r    <= ST_CLEAR;
                                arr_clr_r  <= 1'b1;
                                busy_r     <= 1'b1;
                            end else begin
                                err_r <= 1'b1;
                            end
                        end
                    end
                    ST_CLEAR: begin
                        state_r    <= ST_RUN;
                        op_ready_r <= 1'b1;
                    end
                    ST_RUN: begin
                        if (beat_s) begin
                            for (int i = 0; i < M; i++) begin
                                for (int j = 0; j < M; j++) begin
                                    arr_a_r[i][j] <= op_a_col[i];
                                    arr_b_r[i][j] <= op_b_row[j];
                                end
                            end
                            arr_en_r   <= 1'b1;
                            beat_cnt_r <= beat_cnt_r + K_ONE;
                            if (last_beat_s) begin
                                state_r    <= ST_DRAIN;
                                op_ready_r <= 1'b0;
                            end
                        end
                    end
                    ST_DRAIN: begin
                        // arr_en for the last beat is active during this cycle.
                        state_r     <= ST_RESULT;
                        res_valid_r <= 1'b1;
                    end
                    ST_RESULT: begin
                        if (res_ready) begin
                            state_r     <= ST_IDLE;
                            res_valid_r <= 1'b0;
                            busy_r      <= 1'b0;
                        end
                    end
                    default: begin
                        state_r     <= ST_IDLE;
                        op_ready_r  <= 1'b0;
                        busy_r      <= 1'b0;
                        res_valid_r <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
